spi_shift_register: RTL and testbench

- Parameterised SPI-style shift register with serial-in/serial-out data transfer.
- Parallel-loads a transmit word and shifts it out MSB-first on `serial_out`.
- Shifts the incoming `serial_in` bits into the same register at the same time; the received word appears on `rx_data`.
- Datapath core of the SPI master/slave; the controller drives `load`/`start` and uses `busy`/`done` for sequencing.

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_bit_counter.sv | 30 +++
 rtl/spi_shift_register.sv | 92 +++++++++
 tb/tb_spi_shift_register.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI shift-register datapath: default width,
// transfer state encoding and the bit-counter width helper.
package spi_pkg;

  localparam int SPI_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } spi_state_t;

  // Counter must hold WIDTH itself so it never wraps inside a transfer.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// Clear/enable up-counter of shifted bits; last flags the final shift of a word.
module spi_bit_counter
  import spi_pkg::*;
#(
  parameter int WIDTH = SPI_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int CW = cnt_width(WIDTH);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  assign last = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/spi_shift_register.sv
// SPI serial-in/serial-out shift register with parallel load and received-word capture.
// Build option: define SPI_SHIFT_LSB_FIRST_EN to shift LSB-first instead of MSB-first.
//
// state | meaning
// IDLE  | waiting; load captures tx_data, start begins a transfer
// SHIFT | one bit out/in per clock, WIDTH clocks
// DONE  | one-cycle done pulse, then back to IDLE
module spi_shift_register
  import spi_pkg::*;
#(
  parameter int WIDTH = SPI_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             start,
  input  logic             serial_in,
  output logic             serial_out,
  output logic [WIDTH-1:0] rx_data,
  output logic             busy,
  output logic             done
);

  spi_state_t       state;
  spi_state_t       state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_shift;
  logic             cnt_clr;
  logic             cnt_en;
  logic             cnt_last;

  assign cnt_clr = (state == IDLE) && start;
  assign cnt_en  = (state == SHIFT);

  spi_bit_counter #(
    .WIDTH(WIDTH)
  ) u_bit_counter (
    .clk  (clk),
    .reset(reset),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .last (cnt_last)
  );

`ifdef SPI_SHIFT_LSB_FIRST_EN
  assign shreg_shift = {serial_in, shreg[WIDTH-1:1]};
  assign serial_out  = shreg[0];
`else
  assign shreg_shift = {shreg[WIDTH-2:0], serial_in};
  assign serial_out  = shreg[WIDTH-1];
`endif

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = start ? SHIFT : IDLE;
      SHIFT:   state_nxt = cnt_last ? DONE : SHIFT;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // load/start are only honoured in IDLE, so a running word is never disturbed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg   <= '0;
      rx_data <= '0;
    end else begin
      if (state == IDLE && load) begin
        shreg <= tx_data;
      end else if (state == SHIFT) begin
        shreg <= shreg_shift;
      end
      if (state == SHIFT && cnt_last) begin
        rx_data <= shreg_shift;
      end
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_spi_shift_register.sv
// Self-checking bench for spi_shift_register (default MSB-first build).
module tb_spi_shift_register;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         start = 1'b0;
  logic         si_drv = 1'b0;
  logic         loop_en = 1'b0;
  logic         serial_in;
  logic         serial_out;
  logic [W-1:0] rx_data;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_done_cyc = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] tx;
    logic [W-1:0] rx_in;
    bit           loop;
    int           ign_at;
    logic [W-1:0] exp_rx;
  } vec_t;

  assign serial_in = loop_en ? serial_out : si_drv;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  spi_shift_register #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .tx_data   (tx_data),
    .start     (start),
    .serial_in (serial_in),
    .serial_out(serial_out),
    .rx_data   (rx_data),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called right after a posedge (+1); leaves the DUT back in IDLE.
  task automatic run_xfer(input logic [W-1:0] tx, input logic [W-1:0] rx_in,
                          input bit loop, input int ign_at, input logic [W-1:0] exp_rx);
    int e0;
    logic [W-1:0] prev_rx;
    logic [W-1:0] got;
    prev_rx = rx_data;
    loop_en = loop;
    tx_data = tx;
    load    = 1'b1;
    start   = 1'b1;
    exp_q.push_back(exp_rx);
    step();
    e0    = cyc;
    load  = 1'b0;
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      si_drv = rx_in[W-1-i];
      if (i == ign_at) begin
        start = 1'b1;
        load  = 1'b1;
        tx_data = 8'h11;
      end
      chk("busy_shift", busy, 1'b1);
      chk("no_early_done", done, 1'b0);
      chk("serial_out_bit", serial_out, tx[W-1-i]);
      if (i < W - 1) chk("rx_held", rx_data, prev_rx);
      step();
      start = 1'b0;
      load  = 1'b0;
    end
    chk("done_pulse", done, 1'b1);
    chk("busy_in_done", busy, 1'b0);
    chk("done_latency", cyc - e0, W);
    last_done_cyc = cyc;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      got = exp_q.pop_front();
      chk("rx_data", rx_data, got);
    end
    step();
    chk("done_one_cycle", done, 1'b0);
    chk("busy_idle", busy, 1'b0);
    chk("rx_stable", rx_data, exp_rx);
    loop_en = 1'b0;
  endtask

  vec_t vecs[5];
  int   d1;

  initial begin
    vecs[0] = '{tx: 8'hA5, rx_in: 8'h00, loop: 1, ign_at: -1, exp_rx: 8'hA5};
    vecs[1] = '{tx: 8'h00, rx_in: 8'h3C, loop: 0, ign_at: -1, exp_rx: 8'h3C};
    vecs[2] = '{tx: 8'hC3, rx_in: 8'h00, loop: 1, ign_at: 4,  exp_rx: 8'hC3};
    vecs[3] = '{tx: 8'hF0, rx_in: 8'h0F, loop: 0, ign_at: -1, exp_rx: 8'h0F};
    vecs[4] = '{tx: 8'hFF, rx_in: 8'h00, loop: 1, ign_at: -1, exp_rx: 8'hFF};

    // Reset hold with load asserted and clocks running
    load = 1'b1;
    tx_data = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_serial_out", serial_out, 1'b0);
      chk("rst_rx_data", rx_data, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
    end
    load = 1'b0;
    reset = 1'b1;
    step();
    chk("post_rst_idle", busy, 1'b0);
    chk("post_rst_serial_out", serial_out, 1'b0);

    foreach (vecs[k]) begin
      run_xfer(vecs[k].tx, vecs[k].rx_in, vecs[k].loop, vecs[k].ign_at, vecs[k].exp_rx);
      chk("idle_keeps_shreg", serial_out, vecs[k].loop ? vecs[k].tx[W-1] : vecs[k].rx_in[W-1]);
    end

    // Reset mid-transfer after three shifts
    loop_en = 1'b1;
    tx_data = 8'hF0;
    load = 1'b1;
    start = 1'b1;
    step();
    load = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("pre_abort_busy", busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_rx_data", rx_data, 8'h00);
    chk("abort_serial_out", serial_out, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("abort_no_done", done, 1'b0);
    end
    reset = 1'b1;
    loop_en = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("after_abort_no_done", done, 1'b0);
      chk("after_abort_rx", rx_data, 8'h00);
    end
    run_xfer(8'h5A, 8'h00, 1, -1, 8'h5A);

    // Back-to-back: second start in the cycle right after done
    run_xfer(8'h81, 8'h00, 1, -1, 8'h81);
    d1 = last_done_cyc;
    run_xfer(8'h7E, 8'h00, 1, -1, 8'h7E);
    chk("b2b_done_spacing", last_done_cyc - d1, W + 2);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
